// File: rtl/minisrc_pkg.sv
// Mini SRC control unit shared definitions.
// Opcodes, ALU codes, FSM states and the control bundle.
package minisrc_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  localparam logic [4:0] ALU_ADD = OP_ADD;
  localparam logic [4:0] ALU_SUB = OP_SUB;
  localparam logic [4:0] ALU_AND = OP_AND;
  localparam logic [4:0] ALU_OR  = OP_OR;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RR, C_IMM, C_LDI, C_LD, C_ST,
    C_BR, C_NOP, C_HALT, C_ILL
  } op_class_t;

  typedef struct packed {
    logic       pc_out;
    logic       mdr_out;
    logic       zlow_out;
    logic       c_out;
    logic       pc_in;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       y_in;
    logic       z_in;
    logic       con_in;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic [4:0] alu_op;
    logic       run;
    logic       illegal;
  } ctrl_t;

  function automatic op_class_t op_class(
    input logic [4:0] op
  );
    case (op)
      OP_ADD, OP_SUB,
      OP_AND, OP_OR:    return C_RR;
      OP_ADDI, OP_ANDI,
      OP_ORI:           return C_IMM;
      OP_LDI:           return C_LDI;
      OP_LD:            return C_LD;
      OP_ST:            return C_ST;
      OP_BR:            return C_BR;
      OP_NOP:           return C_NOP;
      OP_HALT:          return C_HALT;
      default:          return C_ILL;
    endcase
  endfunction

  // Immediate forms reuse the reg-reg ALU function.
  function automatic logic [4:0] imm_alu(
    input logic [4:0] op
  );
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/minisrc_control_unit_if.sv
// Control-unit to datapath bundle.
// Master is the control unit, slave the datapath.
interface minisrc_control_unit_if;
  logic [4:0] opcode;
  logic       con_ff;
  logic       mem_ready;
  logic       PCout, MDRout, Zlowout, Cout;
  logic       PCin, IRin, MARin, MDRin;
  logic       Yin, Zin, CONin;
  logic       IncPC, Read, Write;
  logic       Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_op;
  logic       run;
  logic       illegal;

  modport master (
    input  opcode, con_ff, mem_ready,
    output PCout, MDRout, Zlowout, Cout,
    output PCin, IRin, MARin, MDRin,
    output Yin, Zin, CONin,
    output IncPC, Read, Write,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output alu_op, run, illegal
  );

  modport slave (
    output opcode, con_ff, mem_ready,
    input  PCout, MDRout, Zlowout, Cout,
    input  PCin, IRin, MARin, MDRin,
    input  Yin, Zin, CONin,
    input  IncPC, Read, Write,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  alu_op, run, illegal
  );
endinterface

// File: rtl/minisrc_control_unit.sv
// Mini SRC sequencing FSM: fetch T0-T2, execute T3-T7.
// Outputs decode from state and opcode (Moore style).
module minisrc_control_unit
  import minisrc_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  minisrc_control_unit_if.master ctl
);

  state_t    state, state_nxt;
  ctrl_t     c;
  op_class_t cls;

  assign cls = op_class(ctl.opcode);

  // State register; reset forces RST immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_RST;
    else          state <= state_nxt;
  end

  // Step decoder: strobes and next state.
  always_comb begin
    c = '0;
    state_nxt = state;
    c.run = (state != S_RST) && (state != S_HALT);
    unique case (state)
      S_RST: state_nxt = S_T0;
      S_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1;
        c.inc_pc = 1'b1; c.z_in = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        c.zlow_out = 1'b1; c.pc_in = 1'b1;
        c.read = 1'b1; c.mdr_in = 1'b1;
        if (ctl.mem_ready) state_nxt = S_T2;
      end
      S_T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        state_nxt = S_T4;
        unique case (1'b1)
          cls == C_RR, cls == C_IMM: begin
            c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
          end
          cls == C_LDI, cls == C_LD, cls == C_ST: begin
            c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
          end
          cls == C_BR: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
          end
          cls == C_NOP:  state_nxt = S_T0;
          cls == C_HALT: state_nxt = S_HALT;
          default: begin
            c.illegal = 1'b1;
            state_nxt = S_T0;
          end
        endcase
      end
      S_T4: begin
        state_nxt = S_T5;
        unique case (1'b1)
          cls == C_RR: begin
            c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1;
            c.alu_op = ctl.opcode;
          end
          cls == C_IMM: begin
            c.c_out = 1'b1; c.z_in = 1'b1;
            c.alu_op = imm_alu(ctl.opcode);
          end
          cls == C_LDI, cls == C_LD, cls == C_ST: begin
            c.c_out = 1'b1; c.z_in = 1'b1;
            c.alu_op = ALU_ADD;
          end
          cls == C_BR: begin
            c.pc_out = 1'b1; c.y_in = 1'b1;
          end
          default: state_nxt = S_T0;
        endcase
      end
      S_T5: begin
        state_nxt = S_T0;
        unique case (1'b1)
          cls == C_RR, cls == C_IMM, cls == C_LDI: begin
            c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          cls == C_LD, cls == C_ST: begin
            c.zlow_out = 1'b1; c.mar_in = 1'b1;
            state_nxt = S_T6;
          end
          cls == C_BR: begin
            c.c_out = 1'b1; c.z_in = 1'b1;
            c.alu_op = ALU_ADD;
            state_nxt = S_T6;
          end
          default: ;
        endcase
      end
      S_T6: begin
        state_nxt = S_T0;
        unique case (1'b1)
          cls == C_LD: begin
            c.read = 1'b1; c.mdr_in = 1'b1;
            state_nxt = ctl.mem_ready ? S_T7 : S_T6;
          end
          cls == C_ST: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
            state_nxt = S_T7;
          end
          cls == C_BR: begin
            c.zlow_out = 1'b1;
            c.pc_in = ctl.con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        state_nxt = S_T0;
        unique case (1'b1)
          cls == C_LD: begin
            c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          cls == C_ST: begin
            c.write = 1'b1;
            state_nxt = ctl.mem_ready ? S_T0 : S_T7;
          end
          default: ;
        endcase
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  assign ctl.PCout   = c.pc_out;
  assign ctl.MDRout  = c.mdr_out;
  assign ctl.Zlowout = c.zlow_out;
  assign ctl.Cout    = c.c_out;
  assign ctl.PCin    = c.pc_in;
  assign ctl.IRin    = c.ir_in;
  assign ctl.MARin   = c.mar_in;
  assign ctl.MDRin   = c.mdr_in;
  assign ctl.Yin     = c.y_in;
  assign ctl.Zin     = c.z_in;
  assign ctl.CONin   = c.con_in;
  assign ctl.IncPC   = c.inc_pc;
  assign ctl.Read    = c.read;
  assign ctl.Write   = c.write;
  assign ctl.Gra     = c.gra;
  assign ctl.Grb     = c.grb;
  assign ctl.Grc     = c.grc;
  assign ctl.Rin     = c.r_in;
  assign ctl.Rout    = c.r_out;
  assign ctl.BAout   = c.ba_out;
  assign ctl.alu_op  = c.alu_op;
  assign ctl.run     = c.run;
  assign ctl.illegal = c.illegal;

endmodule

// File: doc/minisrc_control_unit.md
# minisrc_control_unit

Moore-style sequencing FSM for the Mini SRC datapath. It walks each instruction through fetch (T0–T2) and execute steps (T3–T7). It drives the select/encode strobes (Gra/Grb/Grc, Rin/Rout/BAout) and the bus, register, ALU and memory control lines. Memory accesses hold Read/Write until the memory acknowledges. The block sits between the instruction register's opcode field and every datapath enable.

## Interface
Parameters:
- none; opcodes, ALU codes and states come from `minisrc_pkg`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 5: IR[31:27] from select/encode; must be stable from T3 until the next T0.
- `con_ff` in 1: branch-condition flag; loaded by `CONin`.
- `mem_ready` in 1: memory acknowledge for the current Read/Write.
- `PCout`, `MDRout`, `Zlowout`, `Cout` out 1 each: bus drivers.
- `PCin`, `IRin`, `MARin`, `MDRin`, `Yin`, `Zin`, `CONin` out 1 each: register loads.
- `IncPC`, `Read`, `Write` out 1 each: PC increment and memory strobes.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout` out 1 each: select/encode controls.
- `alu_op` out 5: ALU operation code.
- `run` out 1: high while executing.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
- All outputs are combinational from state and `opcode`. Any output not listed for a step is 0. `alu_op` is 0 unless listed.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- ADD/SUB/AND/OR (reg-reg):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, `alu_op`=opcode.
  - T5: Zlowout, Gra, Rin → T0.
- ADDI/ANDI/ORI:
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, `alu_op`=ADD/AND/OR.
  - T5: Zlowout, Gra, Rin → T0.
- LDI:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, `alu_op`=ADD.
  - T5: Zlowout, Gra, Rin → T0.
- LD:
  - T3–T4 as LDI.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin → T0.
- ST:
  - T3–T5 as LD.
  - T6: Gra, Rout, MDRin.
  - T7: Write → T0.
- BR:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, `alu_op`=ADD.
  - T6: Zlowout; PCin only if `con_ff`=1 → T0.
- NOP: T3 → T0 with no strobes.
- HALT: T3 → HALT; stays there until reset; `run`=0.
- Any other opcode: `illegal`=1 in T3; T3 → T0, so it executes as NOP.

## Timing
- Reset: while `reset_n`=0, state=RST, immediately and asynchronously.
  - In RST every output is 0, including `run`.
  - After release, RST → T0 on the first edge; `run`=1 from T0 on.
- Memory handshake: applies to T1 (fetch), LD T6 and ST T7.
  - The state holds, with Read/Write and the paired strobes high, until an edge samples `mem_ready`=1.
  - It advances on that edge, so zero wait → 1 cycle and N waits → N+1 cycles.
  - `mem_ready` is ignored in all other states.
- Reset mid-access: Read/Write drop combinationally with the state. No partial writeback occurs.
- Zero-wait instruction length, fetch included: reg-reg/imm/LDI 6 cycles, LD/ST 8, BR 7, NOP 4.
- `con_ff` is sampled combinationally in T6. It must already reflect the CONin load made at the end of T3.
- `opcode` is not latched. It is read in T3–T7 only.

## Structure
- `minisrc_pkg` holds:
  - Opcode constants: LD=00000, LDI=00001, ST=00010, ADD=00011, SUB=00100, AND=00101, OR=00110, ADDI=01100, ANDI=01101, ORI=01110, BR=10010, NOP=11000, HALT=11001.
  - ALU op codes, equal to the matching reg-reg opcodes.
  - The state enumeration.
- Implementation is a single module: a state register plus one combinational output/next-state decoder. No sub-module.

## Test plan
- Reset, then hold `mem_ready`=1 with IR=0x19890000 (add r3,r1,r2) → states RST,T0..T5,T0.
  - T3 shows Grb+Rout+Yin; T4 shows Grc+Rout+Zin with `alu_op`=00011; T5 shows Gra+Rin.
- Fetch with `mem_ready` held 0 for 2 cycles → Read+MDRin high for exactly 3 cycles in T1; PCin stays high throughout; then T2.
- LD with 1 wait state in T6 → Read high 2 cycles; total 9 cycles T0→T0; MDRout+Gra+Rin only in T7.
- BR with `con_ff`=0, then `con_ff`=1 → PCin absent in T6, then present in T6; CONin high only in T3.
- Opcode 11111 → `illegal` one cycle in T3, no Rin/Write, next state T0. Then HALT opcode → `run`=0 and the FSM stays in HALT for 20 cycles.
- Assert `reset_n`=0 mid-T7 of an ST → Write falls in the same cycle and all outputs are 0. After release, the FSM enters T0 after one RST cycle.
